// File: rtl/pipeline_pkg.sv
// Shared types and helpers for the valid/ready skid-buffer pipeline.
// Stage occupancy encoding and the width of the chain-wide occupancy count.
package pipeline_pkg;

    typedef enum logic [1:0] {
        STG_EMPTY = 2'd0,
        STG_ONE   = 2'd1,
        STG_TWO   = 2'd2
    } stage_state_t;

    // Width needed to count 0 .. 2*stages entries.
    function automatic int occ_width(input int stages);
        return $clog2(2 * stages + 1);
    endfunction

    function automatic logic [1:0] stage_count(input stage_state_t s);
        logic [1:0] n;
        n = 2'd0;
        case (s)
            STG_ONE: n = 2'd1;
            STG_TWO: n = 2'd2;
            default: n = 2'd0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/pipeline_skid_stage.sv
// One valid/ready register stage with a 2-entry skid buffer and a registered ready.
// State   | meaning
// EMPTY   | no entry held; main is stale
// ONE     | main holds the oldest entry; skid unused
// TWO     | main is oldest, skid is next; upstream is stalled via rdy_q
module pipeline_skid_stage
    import pipeline_pkg::*;
#(
    parameter int                WIDTH       = 32,
    parameter logic [WIDTH-1:0]  RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       count
);

    stage_state_t     state, state_nxt;
    logic [WIDTH-1:0] main_q, main_nxt;
    logic [WIDTH-1:0] skid_q, skid_nxt;
    logic             rdy_q;
    logic             in_fire;
    logic             out_fire;

    assign in_ready  = rdy_q && !flush;
    assign out_valid = (state != STG_EMPTY);
    assign out_data  = main_q;
    assign count     = stage_count(state);

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    always_comb begin
        state_nxt = state;
        main_nxt  = main_q;
        skid_nxt  = skid_q;
        if (flush) begin
            state_nxt = STG_EMPTY;
            main_nxt  = RESET_VALUE;
            skid_nxt  = RESET_VALUE;
        end else begin
            case (state)
                STG_EMPTY: begin
                    if (in_fire) begin
                        main_nxt  = in_data;
                        state_nxt = STG_ONE;
                    end
                end
                STG_ONE: begin
                    if (in_fire && out_fire) begin
                        main_nxt = in_data;
                    end else if (in_fire) begin
                        skid_nxt  = in_data;
                        state_nxt = STG_TWO;
                    end else if (out_fire) begin
                        state_nxt = STG_EMPTY;
                    end
                end
                STG_TWO: begin
                    // rdy_q is low here, so only the drain side can move
                    if (out_fire) begin
                        main_nxt  = skid_q;
                        state_nxt = STG_ONE;
                    end
                end
                default: begin
                    state_nxt = STG_EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= STG_EMPTY;
            main_q <= RESET_VALUE;
            skid_q <= RESET_VALUE;
            rdy_q  <= 1'b0;
        end else begin
            state  <= state_nxt;
            main_q <= main_nxt;
            skid_q <= skid_nxt;
            rdy_q  <= (state_nxt != STG_TWO);
        end
    end

endmodule

// File: rtl/pipeline_handshake_register.sv
// Chain of STAGES skid-buffered valid/ready stages with broadcast flush.
// Occupancy is the balanced-tree sum of the per-stage entry counts.
module pipeline_handshake_register
    import pipeline_pkg::*;
#(
    parameter int                WIDTH       = 32,
    parameter int                STAGES      = 1,
    parameter logic [WIDTH-1:0]  RESET_VALUE = '0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          flush,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [WIDTH-1:0]              in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [WIDTH-1:0]              out_data,
    output logic [occ_width(STAGES)-1:0]  occupancy
);

    localparam int OCC_W  = occ_width(STAGES);
    localparam int LEAVES = 1 << $clog2(STAGES);

    logic [STAGES:0]  valid;
    logic [STAGES:0]  ready;
    logic [WIDTH-1:0] data  [STAGES+1];
    logic [1:0]       count [STAGES];
    logic [OCC_W-1:0] tree  [1:2*LEAVES-1];

    assign valid[0]      = in_valid;
    assign data[0]       = in_data;
    assign in_ready      = ready[0];
    assign out_valid     = valid[STAGES];
    assign out_data      = data[STAGES];
    assign ready[STAGES] = out_ready;

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        pipeline_skid_stage #(
            .WIDTH       (WIDTH),
            .RESET_VALUE (RESET_VALUE)
        ) u_stage (
            .clk       (clk),
            .reset     (reset),
            .flush     (flush),
            .in_valid  (valid[i]),
            .in_ready  (ready[i]),
            .in_data   (data[i]),
            .out_valid (valid[i+1]),
            .out_ready (ready[i+1]),
            .out_data  (data[i+1]),
            .count     (count[i])
        );
    end

    // Leaves beyond STAGES are padded with zero so the tree stays balanced.
    for (genvar i = 0; i < LEAVES; i++) begin : g_leaf
        if (i < STAGES) begin : g_used
            assign tree[LEAVES+i] = OCC_W'(count[i]);
        end else begin : g_pad
            assign tree[LEAVES+i] = '0;
        end
    end

    for (genvar k = 1; k < LEAVES; k++) begin : g_node
        assign tree[k] = tree[2*k] + tree[2*k+1];
    end

    assign occupancy = tree[1];

endmodule
